mem_wb_stage: RTL and testbench

- Memory/writeback stage of the 3-stage RV32I pipeline. It sits directly downstream of the execute stage and consumes its ALU result, store data, rd and control.
- It drives the synchronous-read dcache, with the address presented in X and data returned in M.
- It owns the M pipeline register, store byte-lane alignment, load extraction and extension, the writeback mux, the forwarding source and csr_tohost.

---
 rtl/mem_wb_pkg.sv | 27 ++
 rtl/mem_wb_stage_load_align.sv | 21 ++
 rtl/mem_wb_stage.sv | 109 ++++++++++
 tb/tb_mem_wb_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared constants and helpers for the memory/writeback stage
package mem_wb_pkg;
    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;
    localparam logic [11:0] CSR_TOHOST_DEFAULT = 12'h51E;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    // size is funct3[1:0]: 0 byte, 1 half, 2 word
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] size);
        return size == 2'b00 ? 4'b0001 : size == 2'b01 ? 4'b0011 : 4'b1111;
    endfunction
endpackage

// File: rtl/mem_wb_stage_load_align.sv
// mem_load_align: selects the addressed lane of a load word and extends it
module mem_load_align
    import mem_wb_pkg::*;
(
    input  logic [31:0] i_dout,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [31:0] w_lane;

    assign w_lane = i_dout >> {i_off, 3'b000};

    // extend the low byte/half of the shifted lane according to width and sign
    always_comb begin
        o_data = i_funct3 == FNC_LB  ? {{24{w_lane[7]}}, w_lane[7:0]} :
                 i_funct3 == FNC_LH  ? {{16{w_lane[15]}}, w_lane[15:0]} :
                 i_funct3 == FNC_LBU ? {24'b0, w_lane[7:0]} :
                 i_funct3 == FNC_LHU ? {16'b0, w_lane[15:0]} : w_lane;
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: M pipeline register, dcache drive, load alignment and writeback
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int          DWIDTH     = 32,
    parameter logic [11:0] CSR_TOHOST = CSR_TOHOST_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic [DWIDTH-1:0] ex_alu_out,
    input  logic [DWIDTH-1:0] ex_store_data,
    input  logic [DWIDTH-1:0] ex_pc_plus4,
    input  logic [4:0]        ex_rd,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic              ex_reg_write,
    input  logic [1:0]        ex_wb_sel,
    input  logic              ex_csr_we,
    input  logic [11:0]       ex_csr_addr,
    input  logic [DWIDTH-1:0] ex_csr_wdata,
    output logic [DWIDTH-1:0] dcache_addr,
    output logic              dcache_re,
    output logic [3:0]        dcache_we,
    output logic [DWIDTH-1:0] dcache_din,
    input  logic [DWIDTH-1:0] dcache_dout,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [DWIDTH-1:0] wb_data,
    output logic              mem_misaligned,
    output logic [DWIDTH-1:0] csr_tohost
);
    logic        w_go;
    logic        w_mis_x;
    logic [31:0] w_load;
    logic [31:0] w_mem_data;

    logic        r_m_valid;
    logic [31:0] r_m_alu;
    logic [31:0] r_m_pc4;
    logic [4:0]  r_m_rd;
    logic [2:0]  r_m_funct3;
    logic [1:0]  r_m_off;
    logic [1:0]  r_m_wb_sel;
    logic        r_m_reg_write;
    logic        r_m_is_load;
    logic        r_m_misaligned;
    logic        r_hold_v;
    logic [31:0] r_hold_data;
    logic [31:0] r_csr_tohost;

    assign w_go        = ex_valid & ~stall & reset;
    assign w_mis_x     = misaligned(ex_funct3[1:0], ex_alu_out[1:0]);
    assign dcache_addr = {ex_alu_out[31:2], 2'b00};
    assign dcache_re   = w_go & ex_is_load;
    assign dcache_we   = (w_go & ex_is_store & ~w_mis_x) ? store_mask(ex_funct3[1:0]) << ex_alu_out[1:0] : 4'b0000;
    assign dcache_din  = ex_store_data << {ex_alu_out[1:0], 3'b000};

    mem_load_align u_align (
        .i_dout   (dcache_dout),
        .i_off    (r_m_off),
        .i_funct3 (r_m_funct3),
        .o_data   (w_load)
    );

    // M register, stall hold buffer and tohost CSR; reset wins over stall
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_m_valid      <= 1'b0;
            r_m_misaligned <= 1'b0;
            r_hold_v       <= 1'b0;
            r_csr_tohost   <= '0;
        end else begin
            if (!stall) begin
                r_m_valid      <= ex_valid;
                r_m_alu        <= ex_alu_out;
                r_m_pc4        <= ex_pc_plus4;
                r_m_rd         <= ex_rd;
                r_m_funct3     <= ex_funct3;
                r_m_off        <= ex_alu_out[1:0];
                r_m_wb_sel     <= ex_wb_sel;
                r_m_reg_write  <= ex_reg_write;
                r_m_is_load    <= ex_is_load;
                r_m_misaligned <= (ex_is_load | ex_is_store) & w_mis_x;
                r_hold_v       <= 1'b0;
            end else if (!r_hold_v && r_m_valid && r_m_is_load) begin
                r_hold_v    <= 1'b1;
                r_hold_data <= w_load;
            end
            if (w_go && ex_csr_we && ex_csr_addr == CSR_TOHOST)
                r_csr_tohost <= ex_csr_wdata;
        end
    end

    assign w_mem_data = r_hold_v ? r_hold_data : w_load;

    // writeback source select; the unused encoding falls back to the ALU result
    always_comb begin
        wb_data = r_m_wb_sel == WB_MEM ? w_mem_data :
                  r_m_wb_sel == WB_PC4 ? r_m_pc4 : r_m_alu;
    end

    assign wb_we          = r_m_valid & r_m_reg_write & ~r_m_misaligned & (r_m_rd != 5'd0);
    assign wb_rd          = r_m_rd;
    assign mem_misaligned = r_m_valid & r_m_misaligned;
    assign csr_tohost     = r_csr_tohost;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed stimulus with a writeback scoreboard for mem_wb_stage
module tb_mem_wb_stage;
    import mem_wb_pkg::*;

    typedef struct packed {
        logic        v;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        ld;
        logic        st;
        logic        rw;
        logic [1:0]  ws;
        logic        cwe;
        logic [11:0] ca;
        logic [31:0] cwd;
    } ins_t;

    typedef struct {
        int          due;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        scramble = 1'b0;
    ins_t        cur = '0;
    logic [31:0] dcache_addr, dcache_din, wb_data, csr_tohost;
    logic [31:0] dcache_dout = 32'h0;
    logic [3:0]  dcache_we;
    logic        dcache_re, wb_we, mem_misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] mem [0:255];
    exp_t        q[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .ex_valid       (cur.v),
        .ex_alu_out     (cur.alu),
        .ex_store_data  (cur.sd),
        .ex_pc_plus4    (cur.pc4),
        .ex_rd          (cur.rd),
        .ex_funct3      (cur.f3),
        .ex_is_load     (cur.ld),
        .ex_is_store    (cur.st),
        .ex_reg_write   (cur.rw),
        .ex_wb_sel      (cur.ws),
        .ex_csr_we      (cur.cwe),
        .ex_csr_addr    (cur.ca),
        .ex_csr_wdata   (cur.cwd),
        .dcache_addr    (dcache_addr),
        .dcache_re      (dcache_re),
        .dcache_we      (dcache_we),
        .dcache_din     (dcache_din),
        .dcache_dout    (dcache_dout),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .mem_misaligned (mem_misaligned),
        .csr_tohost     (csr_tohost)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read data cache; scramble corrupts dout when no read is issued
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (dcache_we[b]) mem[dcache_addr[9:2]][8*b +: 8] <= dcache_din[8*b +: 8];
        if (dcache_re) dcache_dout <= mem[dcache_addr[9:2]];
        else if (scramble) dcache_dout <= 32'h12345678;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", n, act, req, cyc);
        end
    endtask

    // monitor: pops every expectation due at this cycle and compares writeback
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("wb_due", 32'(cyc), 32'(e.due));
            chk("wb_we", 32'(wb_we), 32'(e.we));
            chk("mem_misaligned", 32'(mem_misaligned), 32'(e.mis));
            if (e.we) begin
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic exp_wb(input logic we, input logic [4:0] rd, input logic [31:0] d, input logic mis);
        q.push_back('{cyc + 1, we, rd, d, mis});
    endtask

    task automatic issue(input ins_t i, input logic rs = 1'b1, input logic st = 1'b0);
        @(negedge clk);
        #1;
        reset = rs;
        stall = st;
        cur = i;
        #1;
    endtask

    function automatic ins_t nop();
        ins_t i = '0;
        return i;
    endfunction

    function automatic ins_t st_(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        ins_t i = '0;
        i.v = 1'b1; i.alu = a; i.sd = d; i.f3 = f; i.st = 1'b1;
        return i;
    endfunction

    function automatic ins_t ld_(input logic [31:0] a, input logic [4:0] rd, input logic [2:0] f);
        ins_t i = '0;
        i.v = 1'b1; i.alu = a; i.rd = rd; i.f3 = f; i.ld = 1'b1; i.rw = 1'b1; i.ws = 2'd1;
        return i;
    endfunction

    function automatic ins_t jal_(input logic [4:0] rd, input logic [31:0] pc4);
        ins_t i = '0;
        i.v = 1'b1; i.alu = 32'h0000_3000; i.rd = rd; i.pc4 = pc4; i.rw = 1'b1; i.ws = 2'd2;
        return i;
    endfunction

    function automatic ins_t csr_(input logic [11:0] a, input logic [31:0] d);
        ins_t i = '0;
        i.v = 1'b1; i.cwe = 1'b1; i.ca = a; i.cwd = d;
        return i;
    endfunction

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        // reset holds the dcache quiet even for live instructions
        issue(st_(32'h100, 32'hDEADBEEF, FNC_SW), 1'b0);
        chk("rst_dcache_we", 32'(dcache_we), 32'h0);
        exp_wb(1'b0, 5'd0, 32'h0, 1'b0);
        issue(ld_(32'h100, 5'd5, FNC_LW), 1'b0);
        chk("rst_dcache_re", 32'(dcache_re), 32'h0);
        chk("rst_tohost", csr_tohost, 32'h0);
        exp_wb(1'b0, 5'd0, 32'h0, 1'b0);
        // word store then load
        issue(st_(32'h100, 32'hDEADBEEF, FNC_SW));
        chk("sw_we", 32'(dcache_we), 32'hF);
        chk("sw_din", dcache_din, 32'hDEADBEEF);
        exp_wb(1'b0, 5'd0, 32'h0, 1'b0);
        issue(ld_(32'h100, 5'd5, FNC_LW));
        chk("lw_re", 32'(dcache_re), 32'h1);
        chk("lw_addr", dcache_addr, 32'h100);
        exp_wb(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        // byte store into lane 3, signed and unsigned reads
        issue(st_(32'h103, 32'h000000A5, FNC_SB));
        chk("sb_we", 32'(dcache_we), 32'h8);
        chk("sb_din", dcache_din, 32'hA5000000);
        exp_wb(1'b0, 5'd0, 32'h0, 1'b0);
        issue(ld_(32'h103, 5'd6, FNC_LB));
        chk("lb_addr", dcache_addr, 32'h100);
        exp_wb(1'b1, 5'd6, 32'hFFFFFFA5, 1'b0);
        issue(ld_(32'h103, 5'd7, FNC_LBU));
        exp_wb(1'b1, 5'd7, 32'h000000A5, 1'b0);
        issue(ld_(32'h102, 5'd8, FNC_LH));
        exp_wb(1'b1, 5'd8, 32'hFFFFA5AD, 1'b0);
        issue(ld_(32'h100, 5'd9, FNC_LHU));
        exp_wb(1'b1, 5'd9, 32'h0000BEEF, 1'b0);
        // misaligned store and load
        issue(st_(32'h101, 32'h00001234, FNC_SH));
        chk("sh_mis_we", 32'(dcache_we), 32'h0);
        exp_wb(1'b0, 5'd0, 32'h0, 1'b1);
        issue(ld_(32'h102, 5'd10, FNC_LW));
        chk("lw_mis_re", 32'(dcache_re), 32'h1);
        exp_wb(1'b0, 5'd10, 32'h0, 1'b1);
        // load held across a 3-cycle stall while dcache_dout is corrupted
        issue(ld_(32'h100, 5'd11, FNC_LW));
        exp_wb(1'b1, 5'd11, 32'hA5ADBEEF, 1'b0);
        for (int k = 0; k < 3; k++) begin
            issue(ld_(32'h104, 5'd12, FNC_LW), 1'b1, 1'b1);
            scramble = 1'b1;
            chk("stall_re", 32'(dcache_re), 32'h0);
            exp_wb(1'b1, 5'd11, 32'hA5ADBEEF, 1'b0);
        end
        issue(nop());
        chk("unstall_data", wb_data, 32'hA5ADBEEF);
        exp_wb(1'b0, 5'd0, 32'h0, 1'b0);
        scramble = 1'b0;
        // tohost CSR writes
        issue(csr_(12'h51E, 32'h1));
        exp_wb(1'b0, 5'd0, 32'h0, 1'b0);
        issue(csr_(12'h51F, 32'hFF));
        chk("tohost_set", csr_tohost, 32'h1);
        exp_wb(1'b0, 5'd0, 32'h0, 1'b0);
        issue(csr_(12'h51E, 32'h7), 1'b1, 1'b1);
        chk("tohost_other_addr", csr_tohost, 32'h1);
        exp_wb(1'b0, 5'd0, 32'h0, 1'b0);
        issue(nop());
        chk("tohost_stalled", csr_tohost, 32'h1);
        exp_wb(1'b0, 5'd0, 32'h0, 1'b0);
        // link writeback, x0 suppression
        issue(jal_(5'd1, 32'h2004));
        exp_wb(1'b1, 5'd1, 32'h2004, 1'b0);
        issue(jal_(5'd0, 32'h2004));
        exp_wb(1'b0, 5'd0, 32'h0, 1'b0);
        issue(jal_(5'd3, 32'h2008));
        exp_wb(1'b1, 5'd3, 32'h2008, 1'b0);
        // one-edge reset clears state
        issue(st_(32'h100, 32'h0BADF00D, FNC_SW), 1'b0);
        chk("rst2_dcache_we", 32'(dcache_we), 32'h0);
        exp_wb(1'b0, 5'd0, 32'h0, 1'b0);
        issue(nop());
        chk("rst2_tohost", csr_tohost, 32'h0);
        exp_wb(1'b0, 5'd0, 32'h0, 1'b0);
        issue(nop());
        exp_wb(1'b0, 5'd0, 32'h0, 1'b0);
        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        chk("drain_pending", 32'(q.size()), 32'h0);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
